sda8fir_ctrl: RTL and testbench
===============================

# sda8fir_ctrl

Sequencer for an 8-tap serial distributed-arithmetic (SDA) FIR. It accepts one signed sample per valid/ready handshake and holds the 8-sample tap line. For each sample it walks the 8 input bit-planes MSB-first, addressing an external 256-entry DA LUT and shift-accumulating the returned partial sums. It then presents a registered filter output with a one-cycle valid pulse. It sits between the sample source and the output consumer, trading the parallel DA core's area for one result every 9 clocks.

## Interface
- XW, 8, input sample width, signed two's complement; equals the bit-plane count.
- LUTW, 12, LUT entry width, signed.
- YW, 16, output width, signed.
- Taps fixed at 8, so the LUT address is 8 bits.

- clk  in  1  sole clock; all state changes on its rising edge.
- RstN  in  1  reset, asynchronous and active-low.
- X  in  XW  signed input sample.
- x_valid  in  1  X is valid.
- x_ready  out  1  block can accept a sample; high only in IDLE.
- flush  in  1  clears the tap line to zero; honoured only in IDLE.
- lut_addr  out  8  DA LUT address; bit k = bit b of tap k.
- lut_data  in  LUTW  LUT entry for lut_addr; combinational, same cycle.
- Yn  out  YW  signed filter output, registered.
- y_valid  out  1  one-cycle pulse when Yn updates.
- busy  out  1  high in CALC.
- ovf  out  1  saturation flag; pulses with y_valid.

## Operation
- Reset values: all 8 taps = 0, acc = 0, bit counter = XW-1, state IDLE, Yn = 0, y_valid = 0, x_ready = 1, busy = 0, ovf = 0, lut_addr = 0.
- State IDLE:
  - x_ready = 1.
  - On x_valid: tap[7..1] ← tap[6..0], tap[0] ← X, acc ← 0, bit ← XW-1, go to CALC.
  - flush with x_valid: the flush applies first, then the new sample loads into tap[0].
  - flush alone: all taps ← 0.
- State CALC:
  - lut_addr[k] = tap[k][bit].
  - P = lut_data sign-extended to ACCW = LUTW+XW bits.
  - acc ← (acc <<< 1) + (bit == XW-1 ? −P : P).
  - If bit == 0: load Yn, pulse y_valid, go to IDLE. Otherwise bit ← bit−1.
  - x_valid and flush are ignored; the upstream holds its sample.
- Result: acc = Σ c_k·tap[k], exact in ACCW bits. Yn is the final acc value reduced to YW bits, as set under Configuration.
- lut_addr = 0 in IDLE.
- RstN asserted mid-CALC: immediate return to the reset state. The partial result is discarded and no y_valid is produced.

## Timing
- Handshake: a sample is accepted on edge E0 where x_valid && x_ready.
- Bit-planes 7..0 are consumed on edges E1..E8.
- Yn and y_valid are updated at E8. y_valid is high during the cycle after E8, in which x_ready is also high.
- Latency from acceptance to y_valid: 8 clocks. Minimum sample period: 9 clocks.
- Back-to-back accept on E9 is legal. y_valid then drops at E9 as normal.
- Yn holds its value until the next completion.

## Configuration
- SDA_SAT_EN defined: a final acc outside [−2^(YW−1), 2^(YW−1)−1] clamps to the nearest bound, and ovf pulses with y_valid.
- SDA_SAT_EN undefined: Yn = acc[YW−1:0] (wrap), and ovf is tied to 0.

## Structure
- Package sda_fir_pkg holds:
  - the state enum {IDLE, CALC};
  - the TAPS = 8 constant;
  - the bit-counter width;
  - the ACCW derivation function.
- Sub-module sda_tap_line holds the 8×XW shift register with load/flush and the bit-plane mux producing lut_addr. The FSM, accumulator and output register stay in the top.

## Test plan
LUT model for the first three scenarios: coefficients {1,2,3,4,4,3,2,1}, each entry = sum of the coefficients selected by the address bits.
- Impulse: X = 127, then eight samples of 0 → Yn sequence 127, 254, 381, 508, 508, 381, 254, 127, 0.
- Negative impulse: after reset, X = −128 → first Yn = −128.
- Latency and throughput:
  - x_valid held high continuously → acceptances exactly 9 clocks apart.
  - y_valid pulse 8 clocks after each acceptance.
  - x_ready low throughout CALC.
- Overflow (all coefficients 100, all taps 127, true sum 101600):
  - With SDA_SAT_EN → Yn = 32767 and ovf = 1.
  - Without → Yn = −29472 and ovf = 0.
- Control events:
  - flush in IDLE after nonzero history, then X = 0 → Yn = 0.
  - RstN pulsed at the 4th CALC cycle → no y_valid; Yn = 0; x_ready = 1 the next cycle; the next impulse is reproduced exactly.

Source files
------------

// File: rtl/sda_fir_pkg.sv
// rtl/sda_fir_pkg.sv - shared widths, state type and accumulator width helper for the SDA FIR sequencer
package sda_fir_pkg;

    localparam int XW   = 8;
    localparam int LUTW = 12;
    localparam int YW   = 16;
    localparam int TAPS = 8;
    localparam int BCW  = $clog2(XW);

    // Worst-case DA sum grows by one bit per bit-plane on top of the LUT entry width.
    function automatic int acc_width(input int lutw, input int xw);
        return lutw + xw;
    endfunction

    localparam int ACCW = acc_width(LUTW, XW);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/sda8fir_ctrl_if.sv
// rtl/sda8fir_ctrl_if.sv - sample, LUT and result signals of the SDA FIR sequencer
interface sda8fir_ctrl_if;
    import sda_fir_pkg::*;

    logic signed [XW-1:0]   X;
    logic                   x_valid;
    logic                   x_ready;
    logic                   flush;
    logic [TAPS-1:0]        lut_addr;
    logic signed [LUTW-1:0] lut_data;
    logic signed [YW-1:0]   Yn;
    logic                   y_valid;
    logic                   busy;
    logic                   ovf;

    modport slave (
        input  X, x_valid, flush, lut_data,
        output x_ready, lut_addr, Yn, y_valid, busy, ovf
    );

    modport master (
        output X, x_valid, flush, lut_data,
        input  x_ready, lut_addr, Yn, y_valid, busy, ovf
    );

endinterface

// File: rtl/sda_tap_line.sv
// rtl/sda_tap_line.sv - 8-sample tap shift register with flush and bit-plane LUT address mux
module sda_tap_line
    import sda_fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 RstN,
    input  logic                 load,
    input  logic                 flush,
    input  logic signed [XW-1:0] sample,
    input  logic [BCW-1:0]       bit_sel,
    input  logic                 addr_en,
    output logic [TAPS-1:0]      addr
);

    logic [TAPS-1:0][XW-1:0] taps;

    // A flush coinciding with a load clears the history before the new sample enters tap 0.
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            taps <= '0;
        end else if (load) begin
            if (flush) begin
                taps <= {{((TAPS-1)*XW){1'b0}}, sample};
            end else begin
                taps <= {taps[TAPS-2:0], sample};
            end
        end else if (flush) begin
            taps <= '0;
        end
    end

    always_comb begin
        addr = '0;
        for (int k = 0; k < TAPS; k++) begin
            addr[k] = addr_en & taps[k][bit_sel];
        end
    end

endmodule

// File: rtl/sda8fir_ctrl.sv
// rtl/sda8fir_ctrl.sv - serial DA 8-tap FIR sequencer top; SDA_SAT_EN selects saturating output
module sda8fir_ctrl
    import sda_fir_pkg::*;
(
    input  logic          clk,
    input  logic          RstN,
    sda8fir_ctrl_if.slave bus
);

    state_t                 state;
    state_t                 state_nxt;
    logic [BCW-1:0]         bit_cnt;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_nxt;
    logic signed [ACCW-1:0] part;
    logic                   in_idle;
    logic                   in_calc;
    logic                   accept;
    logic                   flush_en;
    logic                   last_bit;
    logic signed [YW-1:0]   y_res;
    logic                   ovf_res;

    assign accept   = in_idle & bus.x_valid;
    assign flush_en = in_idle & bus.flush;
    assign last_bit = (bit_cnt == '0);

    sda_tap_line u_tap_line (
        .clk     (clk),
        .RstN    (RstN),
        .load    (accept),
        .flush   (flush_en),
        .sample  (bus.X),
        .bit_sel (bit_cnt),
        .addr_en (in_calc),
        .addr    (bus.lut_addr)
    );

    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.x_valid) state_nxt = CALC;
            CALC:    if (last_bit)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_idle     = (state == IDLE);
        in_calc     = (state == CALC);
        bus.x_ready = in_idle;
        bus.busy    = in_calc;
    end

    // The MSB plane carries the negative weight of two's complement samples.
    always_comb begin
        part    = {{XW{bus.lut_data[LUTW-1]}}, bus.lut_data};
        acc_nxt = (acc <<< 1) + ((bit_cnt == BCW'(XW-1)) ? -part : part);
    end

`ifdef SDA_SAT_EN
    localparam logic signed [ACCW-1:0] Y_MAX = ACCW'((1 << (YW-1)) - 1);
    localparam logic signed [ACCW-1:0] Y_MIN = ACCW'(-(1 << (YW-1)));

    always_comb begin
        y_res   = acc_nxt[YW-1:0];
        ovf_res = 1'b0;
        if (acc_nxt > Y_MAX) begin
            y_res   = Y_MAX[YW-1:0];
            ovf_res = 1'b1;
        end else if (acc_nxt < Y_MIN) begin
            y_res   = Y_MIN[YW-1:0];
            ovf_res = 1'b1;
        end
    end
`else
    always_comb begin
        y_res   = acc_nxt[YW-1:0];
        ovf_res = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            acc         <= '0;
            bit_cnt     <= BCW'(XW-1);
            bus.Yn      <= '0;
            bus.y_valid <= 1'b0;
            bus.ovf     <= 1'b0;
        end else begin
            bus.y_valid <= 1'b0;
            bus.ovf     <= 1'b0;
            if (accept) begin
                acc     <= '0;
                bit_cnt <= BCW'(XW-1);
            end else if (in_calc) begin
                acc <= acc_nxt;
                if (last_bit) begin
                    bus.Yn      <= y_res;
                    bus.y_valid <= 1'b1;
                    bus.ovf     <= ovf_res;
                end else begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sda8fir_ctrl.sv
// tb/tb_sda8fir_ctrl.sv - directed vector bench for sda8fir_ctrl with a behavioural DA LUT
`timescale 1ns/1ps
module tb_sda8fir_ctrl;
    import sda_fir_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sda8fir_ctrl_if bus();

    sda8fir_ctrl dut (
        .clk  (clk),
        .RstN (rst_n),
        .bus  (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic big_coef = 1'b0;
    int   coef_a [TAPS] = '{1, 2, 3, 4, 4, 3, 2, 1};

    always @(posedge clk) cyc <= cyc + 1;

    // LUT entry = sum of the coefficients whose address bit is set
    always_comb begin
        int s;
        s = 0;
        for (int k = 0; k < TAPS; k++) begin
            if (bus.lut_addr[k]) s += big_coef ? 100 : coef_a[k];
        end
        bus.lut_data = LUTW'(s);
    end

`ifdef SDA_SAT_EN
    localparam logic signed [15:0] OVF_Y = 16'sd32767;
    localparam logic               OVF_F = 1'b1;
`else
    localparam logic signed [15:0] OVF_Y = -16'sd29472;
    localparam logic               OVF_F = 1'b0;
`endif

    typedef struct {
        logic              fl;
        logic signed [7:0] x;
        logic              big;
        logic              chk;
        logic signed [15:0] exp_y;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs[$];

    logic mon_en = 1'b0;
    int   acc_cyc[$];
    int   yv_cyc[$];
    int   ready_in_calc = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.x_valid && bus.x_ready) acc_cyc.push_back(cyc);
            if (bus.y_valid) yv_cyc.push_back(cyc);
            if (bus.busy && bus.x_ready) ready_in_calc++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic fl, input logic signed [7:0] x, input logic big,
                                    input logic chk, input logic signed [15:0] y, input logic o);
        vec_t v;
        v.fl = fl; v.x = x; v.big = big; v.chk = chk; v.exp_y = y; v.exp_ovf = o;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.X = '0; bus.x_valid = 1'b0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_sample(input logic fl, input logic signed [XW-1:0] xv,
                              output logic signed [YW-1:0] y, output logic ov,
                              output int lat, output int rdy_hi);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.x_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.X = xv; bus.x_valid = 1'b1; bus.flush = fl;
        @(posedge clk); #1;
        bus.x_valid = 1'b0; bus.flush = 1'b0;
        lat = 0; rdy_hi = 0;
        while (!bus.y_valid && lat < 20) begin
            if (bus.x_ready) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
        y  = bus.Yn;
        ov = bus.ovf;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic signed [YW-1:0] y;
        logic ov;
        int lat, rdy_hi, n, yv_seen;

        bus.X = '0; bus.x_valid = 1'b0; bus.flush = 1'b0;
        do_reset();

        check("reset_x_ready", bus.x_ready, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_y_valid", bus.y_valid, 0);
        check("reset_Yn", bus.Yn, 0);
        check("reset_ovf", bus.ovf, 0);
        check("reset_lut_addr", bus.lut_addr, 0);

        run_sample(1'b0, -8'sd128, y, ov, lat, rdy_hi);
        check("neg_impulse_Yn", y, -128);
        check("neg_impulse_ovf", ov, 0);
        check("neg_impulse_lat", lat, 8);

        do_reset();

        add_vec(0,  8'sd127, 0, 1,  16'sd127, 0);
        add_vec(0,  8'sd0,   0, 1,  16'sd254, 0);
        add_vec(0,  8'sd0,   0, 1,  16'sd381, 0);
        add_vec(0,  8'sd0,   0, 1,  16'sd508, 0);
        add_vec(0,  8'sd0,   0, 1,  16'sd508, 0);
        add_vec(0,  8'sd0,   0, 1,  16'sd381, 0);
        add_vec(0,  8'sd0,   0, 1,  16'sd254, 0);
        add_vec(0,  8'sd0,   0, 1,  16'sd127, 0);
        add_vec(0,  8'sd0,   0, 1,  16'sd0,   0);
        add_vec(0,  8'sd127, 1, 1,  16'sd12700, 0);
        add_vec(0,  8'sd127, 1, 1,  16'sd25400, 0);
        for (int i = 0; i < 5; i++) add_vec(0, 8'sd127, 1, 0, 16'sd0, 0);
        add_vec(0,  8'sd127, 1, 1,  OVF_Y, OVF_F);
        add_vec(1,  8'sd5,   0, 1,  16'sd5, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            big_coef = vecs[i].big;
            run_sample(vecs[i].fl, vecs[i].x, y, ov, lat, rdy_hi);
            check($sformatf("vec%0d_lat", i), lat, 8);
            check($sformatf("vec%0d_ready_in_calc", i), rdy_hi, 0);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_Yn", i), y, vecs[i].exp_y);
                check($sformatf("vec%0d_ovf", i), ov, vecs[i].exp_ovf);
            end
        end
        big_coef = 1'b0;

        // flush alone in IDLE wipes the tap holding 5
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("idle_lut_addr", bus.lut_addr, 0);
        run_sample(1'b0, 8'sd0, y, ov, lat, rdy_hi);
        check("flush_Yn", y, 0);

        // continuous x_valid: back-to-back acceptances
        @(posedge clk); #1;
        bus.X = 8'sd0; bus.x_valid = 1'b1; mon_en = 1'b1;
        repeat (29) @(posedge clk);
        #1;
        bus.x_valid = 1'b0; mon_en = 1'b0;
        check("tput_accept_count_ge3", acc_cyc.size() >= 3, 1);
        check("tput_yvalid_count_ge3", yv_cyc.size() >= 3, 1);
        if (acc_cyc.size() >= 3 && yv_cyc.size() >= 3) begin
            check("tput_gap0", acc_cyc[1] - acc_cyc[0], 9);
            check("tput_gap1", acc_cyc[2] - acc_cyc[1], 9);
            for (int i = 0; i < 3; i++)
                check($sformatf("tput_lat%0d", i), yv_cyc[i] - (acc_cyc[i] + 1), 8);
        end
        check("tput_ready_in_calc", ready_in_calc, 0);
        n = 0;
        while (!bus.x_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("tput_drain_ready", bus.x_ready, 1);

        // reset during the 4th CALC cycle discards the result
        run_sample(1'b0, 8'sd100, y, ov, lat, rdy_hi);
        check("pre_abort_Yn", y, 100);
        @(negedge clk);
        bus.X = 8'sd50; bus.x_valid = 1'b1;
        @(posedge clk); #1;
        bus.x_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_x_ready", bus.x_ready, 1);
        check("abort_Yn", bus.Yn, 0);
        check("abort_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        yv_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.y_valid) yv_seen++;
        end
        check("abort_no_y_valid", yv_seen, 0);
        check("abort_ready_after", bus.x_ready, 1);
        run_sample(1'b0, 8'sd127, y, ov, lat, rdy_hi);
        check("post_abort_Yn0", y, 127);
        check("post_abort_lat", lat, 8);
        run_sample(1'b0, 8'sd0, y, ov, lat, rdy_hi);
        check("post_abort_Yn1", y, 254);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
